// File: rtl/phv_queue_arbiter.sv
// phv_queue_arbiter: four per-queue PHV FIFOs merged round-robin into one
// registered output port tagged with the source queue ID.
module phv_queue_arbiter #(
  parameter int unsigned PHV_LEN    = 32*64+256,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                 axis_clk,
  input  logic                 aresetn,
  input  logic [PHV_LEN-1:0]   phv_in_0,
  input  logic [PHV_LEN-1:0]   phv_in_1,
  input  logic [PHV_LEN-1:0]   phv_in_2,
  input  logic [PHV_LEN-1:0]   phv_in_3,
  input  logic                 phv_in_valid_0,
  input  logic                 phv_in_valid_1,
  input  logic                 phv_in_valid_2,
  input  logic                 phv_in_valid_3,
  output logic                 phv_fifo_ready_0,
  output logic                 phv_fifo_ready_1,
  output logic                 phv_fifo_ready_2,
  output logic                 phv_fifo_ready_3,
  output logic [PHV_LEN-1:0]   phv_out,
  output logic                 phv_out_valid,
  output logic [1:0]           phv_out_qid,
  input  logic                 phv_out_ready,
  output logic                 ovf_err,
  output logic [FIFO_AW:0]     q_count_0,
  output logic [FIFO_AW:0]     q_count_1,
  output logic [FIFO_AW:0]     q_count_2,
  output logic [FIFO_AW:0]     q_count_3
);

  localparam int unsigned NQ = 4;
  localparam int unsigned CW = FIFO_AW + 1;

  logic [PHV_LEN-1:0] phv_in_w [NQ];
  logic [NQ-1:0]      in_valid;

  logic [PHV_LEN-1:0] mem_q [NQ][FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q [NQ];
  logic [FIFO_AW-1:0] wr_ptr_d [NQ];
  logic [FIFO_AW-1:0] rd_ptr_q [NQ];
  logic [FIFO_AW-1:0] rd_ptr_d [NQ];
  logic [CW-1:0]      count_q  [NQ];
  logic [CW-1:0]      count_d  [NQ];

  logic [NQ-1:0]      full;
  logic [NQ-1:0]      empty;
  logic [NQ-1:0]      push;
  logic [NQ-1:0]      pop;

  logic [1:0]         rr_last_q, rr_last_d;
  logic [1:0]         cand;
  logic               grant_found;
  logic [1:0]         grant_idx;
  logic               out_free;
  logic               load;
  logic [PHV_LEN-1:0] head;

  logic [PHV_LEN-1:0] phv_out_q, phv_out_d;
  logic               phv_out_valid_q, phv_out_valid_d;
  logic [1:0]         phv_out_qid_q, phv_out_qid_d;
  logic               ovf_q, ovf_d;

  assign phv_in_w[0] = phv_in_0;
  assign phv_in_w[1] = phv_in_1;
  assign phv_in_w[2] = phv_in_2;
  assign phv_in_w[3] = phv_in_3;
  assign in_valid    = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};

  // Ready is derived only from the registered occupancy.
  assign phv_fifo_ready_0 = ~full[0];
  assign phv_fifo_ready_1 = ~full[1];
  assign phv_fifo_ready_2 = ~full[2];
  assign phv_fifo_ready_3 = ~full[3];

  assign q_count_0     = count_q[0];
  assign q_count_1     = count_q[1];
  assign q_count_2     = count_q[2];
  assign q_count_3     = count_q[3];
  assign phv_out       = phv_out_q;
  assign phv_out_valid = phv_out_valid_q;
  assign phv_out_qid   = phv_out_qid_q;
  assign ovf_err       = ovf_q;

  // Per-queue full/empty status and accepted pushes.
  always_comb begin
    full  = '0;
    empty = '0;
    push  = '0;
    for (int i = 0; i < NQ; i++) begin
      full[i]  = (count_q[i] == CW'(FIFO_DEPTH));
      empty[i] = (count_q[i] == '0);
      push[i]  = in_valid[i] && !full[i];
    end
  end

  // Round-robin search starting one past the last granted queue.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 1; k <= NQ; k++) begin
      cand = rr_last_q + 2'(k);
      if (!grant_found && !empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Output load decision, per-queue pops and head-of-queue selection.
  always_comb begin
    out_free = !phv_out_valid_q || phv_out_ready;
    load     = out_free && grant_found;
    pop      = '0;
    for (int i = 0; i < NQ; i++) begin
      pop[i] = load && (grant_idx == 2'(i));
    end
    head = mem_q[grant_idx][rd_ptr_q[grant_idx]];
  end

  // Next-state for pointers, counts, arbiter and output register.
  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + FIFO_AW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + FIFO_AW'(pop[i]);
      count_d[i]  = count_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
    rr_last_d       = rr_last_q;
    phv_out_d       = phv_out_q;
    phv_out_valid_d = phv_out_valid_q;
    phv_out_qid_d   = phv_out_qid_q;
    ovf_d           = ovf_q | (|(in_valid & full));
    if (out_free) begin
      phv_out_valid_d = load;
      if (load) begin
        phv_out_d     = head;
        phv_out_qid_d = grant_idx;
        rr_last_d     = grant_idx;
      end
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge axis_clk) begin
    if (!aresetn) begin
      for (int i = 0; i < NQ; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_last_q       <= 2'd3;
      phv_out_q       <= '0;
      phv_out_valid_q <= 1'b0;
      phv_out_qid_q   <= 2'd0;
      ovf_q           <= 1'b0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      rr_last_q       <= rr_last_d;
      phv_out_q       <= phv_out_d;
      phv_out_valid_q <= phv_out_valid_d;
      phv_out_qid_q   <= phv_out_qid_d;
      ovf_q           <= ovf_d;
    end
  end

  // FIFO storage; reset-free so it can map onto RAM.
  always_ff @(posedge axis_clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i]] <= phv_in_w[i];
      end
    end
  end

endmodule

// File: doc/phv_queue_arbiter.md
# phv_queue_arbiter

Per-queue PHV buffering and round-robin merge block that sits after the last match-action stage. It accepts up to four PHV streams, one per output queue, each gated by its own valid and ready. Each stream is stored in a dedicated FIFO. The FIFOs are drained through a single registered output port that carries the PHV and its queue ID to the deparser side. The per-queue readies are the `phv_fifo_ready_*` signals the last stage ANDs together.

## Interface
- PHV_LEN, 32*64+256, PHV width in bits.
- FIFO_DEPTH, 16, entries per queue FIFO; power of two, at least 2.
- FIFO_AW, 4, log2(FIFO_DEPTH).
- axis_clk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- phv_in_q (q=0..3)  in  PHV_LEN  PHV for queue q
- phv_in_valid_q (q=0..3)  in  1  PHV valid for queue q
- phv_fifo_ready_q (q=0..3)  out  1  queue q FIFO can accept; equals ~full_q
- phv_out  out  PHV_LEN  merged PHV, registered
- phv_out_valid  out  1  phv_out holds an entry
- phv_out_qid  out  2  source queue of phv_out
- phv_out_ready  in  1  downstream accepts
- ovf_err  out  1  sticky; set when phv_in_valid_q=1 while phv_fifo_ready_q=0
- q_count_q (q=0..3)  out  FIFO_AW+1  current occupancy of queue q

## Operation
- Four independent FIFOs, each with:
  - write pointer, read pointer (FIFO_AW bits, wrapping modulo FIFO_DEPTH), and a count register (0..FIFO_DEPTH).
  - full_q = (count_q == FIFO_DEPTH); empty_q = (count_q == 0).
- Push on queue q when phv_in_valid_q && phv_fifo_ready_q. A valid with ready low is dropped and sets ovf_err. ovf_err clears only on reset.
- Output register is "free" when !phv_out_valid || phv_out_ready.
- When free and at least one queue is non-empty, the output register loads:
  - the head of the granted queue into phv_out;
  - the granted index into phv_out_qid;
  - phv_out_valid=1;
  - and the granted queue pops.
- When free and all queues are empty, phv_out_valid goes to 0.
- Round-robin arbitration:
  - rr_last holds the last granted queue, reset value 3.
  - The search order is rr_last+1, +2, +3, +4 (mod 4). The first non-empty queue wins.
  - rr_last updates only on a load.
- Simultaneous push and pop on the same queue leaves count unchanged; both pointers advance.
- A pop on a full queue frees it. phv_fifo_ready_q rises in the following cycle, because it is derived from the registered count. The same-cycle push on a full queue is still refused.
- FIFO ordering is strict per queue. Inter-queue order follows arbitration only.
- Memory is inferred RAM/registers, reset-free. Only pointers, counts and control are reset.

## Timing
- Reset values:
  - phv_out=0, phv_out_valid=0, phv_out_qid=0
  - phv_fifo_ready_q=1, q_count_q=0, ovf_err=0
  - all pointers 0, rr_last=3
- Reset applied mid-operation discards all queued and output entries on the next edge. phv_out_valid is 0 in the first cycle after.
- Latency: a push accepted in cycle N gives count_q>=1 in cycle N+1. If the output is free and the queue wins arbitration, phv_out_valid=1 in cycle N+2.
- Throughput: one PHV per cycle aggregate while phv_out_ready=1.
- While phv_out_valid=1 and phv_out_ready=0, phv_out, phv_out_qid and phv_out_valid hold stable.
- phv_fifo_ready_q depends only on registered state; there is no combinational path from the inputs.

## Test plan
- Reset check: hold aresetn=0 for 3 cycles -> all outputs at their reset values, all four readies =1, ovf_err=0.
- Single push: push A on queue 2 at cycle 10 with phv_out_ready=1 -> phv_out=A, qid=2, valid=1 in cycle 12 only; q_count_2 is 1 in cycle 11 and 0 in cycle 12.
- Simultaneous fan-out: push the same PHV to all four queues in one cycle, then idle -> four consecutive output beats with qid 0,1,2,3.
- Backpressure/full:
  - With phv_out_ready=0, push 17 PHVs into queue 1.
  - After the first beat loads into the output register, the queue FIFO fills with 16 more entries; ready_1 drops the cycle after it fills.
  - The next valid sets ovf_err=1 and is dropped.
  - Raise ready -> all accepted PHVs drain in push order with qid=1, and ovf_err stays 1.
- Fairness: queues 0 and 3 continuously non-empty, phv_out_ready=1 -> qid sequence alternates 0,3,0,3. Adding queue 1 gives 0,1,3,0,1,3.
- Mid-operation reset: 5 entries queued across queues and valid output held under backpressure, then assert aresetn=0 for 1 cycle -> the next cycle shows counts 0 and valid 0. A new push then appears with the normal 2-cycle latency.
